// File: rtl/request_manager.sv
// request_manager
//   Call-request front end for the 4-storey car. Latches car and hall buttons
//   on their rising edge, clears every call at the floor being served while the
//   door is open, and reports the pending-call vector plus SCAN direction needs
//   to state_control.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   switch              master switch, 0 = out of service (flush all calls)
//   car_btn             in-car buttons, bit i = floor i+1
//   hall_up / hall_dn   hall buttons (up: floors 1..N-1, down: floors 2..N)
//   position            one-hot car floor
//   ud_mode             00 idle, 01 up, 10 down
//   opendoor            door-open command
//   allReq_reg          pending calls per floor
//   up_need / down_need serviceable call above / below the car
//   car_lamp / up_lamp / dn_lamp   request flop mirrors
module request_manager #(
  parameter int N_FLOORS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                switch,
  input  logic [N_FLOORS-1:0] car_btn,
  input  logic [N_FLOORS-2:0] hall_up,
  input  logic [N_FLOORS-2:0] hall_dn,
  input  logic [N_FLOORS-1:0] position,
  input  logic [1:0]          ud_mode,
  input  logic                opendoor,
  output logic [N_FLOORS-1:0] allReq_reg,
  output logic                up_need,
  output logic                down_need,
  output logic [N_FLOORS-1:0] car_lamp,
  output logic [N_FLOORS-2:0] up_lamp,
  output logic [N_FLOORS-2:0] dn_lamp
);

  // Hall-up flops cover floors 1..N-1 and hall-down floors 2..N, so the
  // "no up call at top / no down call at bottom" bits simply do not exist.
  logic [N_FLOORS-1:0] car_req, car_q;
  logic [N_FLOORS-2:0] up_req, up_q;
  logic [N_FLOORS-2:0] dn_req, dn_q;

  logic [N_FLOORS-1:0] car_set;
  logic [N_FLOORS-2:0] up_set, dn_set;
  logic [N_FLOORS-1:0] clr;
  logic [N_FLOORS-1:0] all_req;
  logic [N_FLOORS-1:0] above_mask, below_mask;
  logic                pos_ok, above, below;

  assign car_set = car_btn & ~car_q;
  assign up_set  = hall_up & ~up_q;
  assign dn_set  = hall_dn & ~dn_q;

  // A garbled position (none or several bits) must not clear anything and
  // must not steer the car.
  assign pos_ok = (position != '0) &&
                  ((position & (position - N_FLOORS'(1))) == '0);

  assign clr = (switch && opendoor && pos_ok) ? position : '0;

  // History flops track the buttons even when out of service, so a button
  // held across switch-on does not look like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= car_btn;
      up_q  <= hall_up;
      dn_q  <= hall_dn;
    end
  end

  // Clear beats set at the served floor: a press with the door open there is
  // already being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
    end else if (!switch) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
    end else begin
      car_req <= (car_req | car_set) & ~clr;
      up_req  <= (up_req  | up_set)  & ~clr[N_FLOORS-2:0];
      dn_req  <= (dn_req  | dn_set)  & ~clr[N_FLOORS-1:1];
    end
  end

  assign all_req = car_req | {1'b0, up_req} | {dn_req, 1'b0};

  // above_mask[i] = some position bit below i (car is under floor i);
  // below_mask[i] = some position bit above i.
  always_comb begin
    logic acc_lo, acc_hi;
    above_mask = '0;
    below_mask = '0;
    acc_lo = 1'b0;
    acc_hi = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above_mask[i] = acc_lo;
      acc_lo = acc_lo | position[i];
    end
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      below_mask[i] = acc_hi;
      acc_hi = acc_hi | position[i];
    end
  end

  assign above = pos_ok && ((all_req & above_mask) != '0);
  assign below = pos_ok && ((all_req & below_mask) != '0);

  // SCAN hold: while descending with work still below, hide calls above so
  // the car does not reverse mid-sweep.
  always_comb begin
    if (ud_mode == 2'b10 && below) begin
      up_need   = 1'b0;
      down_need = 1'b1;
    end else begin
      up_need   = above;
      down_need = below;
    end
  end

  assign allReq_reg = all_req;
  assign car_lamp   = car_req;
  assign up_lamp    = up_req;
  assign dn_lamp    = dn_req;

endmodule

// File: tb/tb_request_manager.sv
module tb_request_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       switch;
  logic [3:0] car_btn;
  logic [2:0] hall_up, hall_dn;
  logic [3:0] position;
  logic [1:0] ud_mode;
  logic       opendoor;
  logic [3:0] allReq_reg;
  logic       up_need, down_need;
  logic [3:0] car_lamp;
  logic [2:0] up_lamp, dn_lamp;

  int n_checks = 0;
  int n_fail   = 0;

  request_manager #(.N_FLOORS(4)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch),
    .car_btn(car_btn), .hall_up(hall_up), .hall_dn(hall_dn),
    .position(position), .ud_mode(ud_mode), .opendoor(opendoor),
    .allReq_reg(allReq_reg), .up_need(up_need), .down_need(down_need),
    .car_lamp(car_lamp), .up_lamp(up_lamp), .dn_lamp(dn_lamp)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    car_btn = '0; hall_up = '0; hall_dn = '0; opendoor = 1'b0;
    switch = 1'b0;
    step();
    switch = 1'b1;
    step();
  endtask

  task automatic test_reset();
    position = 4'b0001; ud_mode = 2'b00;
    car_btn = 4'b0110; hall_up = 3'b001;
    step();
    n_checks++;
    if (allReq_reg !== 4'b0111) begin
      n_fail++; $display("FAIL reset_pre_set: got %b want %b", allReq_reg, 4'b0111);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (allReq_reg !== 4'b0000 || car_lamp !== 4'b0000 || up_lamp !== 3'b000) begin
      n_fail++; $display("FAIL reset_async: got req %b car %b up %b want 0", allReq_reg, car_lamp, up_lamp);
    end
    n_checks++;
    if (up_need !== 1'b0 || down_need !== 1'b0) begin
      n_fail++; $display("FAIL reset_need: got %b%b want 00", up_need, down_need);
    end
    car_btn = '0; hall_up = '0;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (allReq_reg !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: got %b want 0000", allReq_reg);
    end
    step();
    n_checks++;
    if (allReq_reg !== 4'b0000) begin
      n_fail++; $display("FAIL reset_no_restore: got %b want 0000", allReq_reg);
    end
  endtask

  task automatic test_set();
    clear_all();
    position = 4'b0001; ud_mode = 2'b00;
    car_btn = 4'b0100;
    #1;
    n_checks++;
    if (allReq_reg !== 4'b0000) begin
      n_fail++; $display("FAIL set_before_edge: got %b want 0000", allReq_reg);
    end
    step();
    car_btn = 4'b0000;
    n_checks++;
    if (allReq_reg !== 4'b0100 || car_lamp !== 4'b0100) begin
      n_fail++; $display("FAIL set_latch: got req %b lamp %b want 0100", allReq_reg, car_lamp);
    end
    n_checks++;
    if (up_need !== 1'b1 || down_need !== 1'b0) begin
      n_fail++; $display("FAIL set_need: got %b%b want 10", up_need, down_need);
    end
  endtask

  task automatic test_hold_clear();
    clear_all();
    position = 4'b0001; ud_mode = 2'b00;
    car_btn = 4'b1000;
    step();
    n_checks++;
    if (car_lamp !== 4'b1000) begin
      n_fail++; $display("FAIL hold_set: got %b want 1000", car_lamp);
    end
    position = 4'b1000;
    #1;
    n_checks++;
    if (up_need !== 1'b0 || down_need !== 1'b0) begin
      n_fail++; $display("FAIL top_need: got %b%b want 00", up_need, down_need);
    end
    opendoor = 1'b1;
    repeat (3) step();
    opendoor = 1'b0;
    n_checks++;
    if (car_lamp !== 4'b0000) begin
      n_fail++; $display("FAIL hold_clear: got %b want 0000", car_lamp);
    end
    repeat (15) step();
    n_checks++;
    if (allReq_reg !== 4'b0000) begin
      n_fail++; $display("FAIL hold_no_refire: got %b want 0000", allReq_reg);
    end
    car_btn = 4'b0000;
    step();
    car_btn = 4'b1000;
    step();
    car_btn = 4'b0000;
    n_checks++;
    if (car_lamp !== 4'b1000) begin
      n_fail++; $display("FAIL hold_repress: got %b want 1000", car_lamp);
    end
  endtask

  task automatic test_scan();
    clear_all();
    position = 4'b0001; ud_mode = 2'b00;
    car_btn = 4'b1001;
    step();
    car_btn = 4'b0000;
    position = 4'b0100;
    ud_mode = 2'b10; #1;
    n_checks++;
    if ({up_need, down_need} !== 2'b01) begin
      n_fail++; $display("FAIL scan_down: got %b%b want 01", up_need, down_need);
    end
    ud_mode = 2'b01; #1;
    n_checks++;
    if ({up_need, down_need} !== 2'b11) begin
      n_fail++; $display("FAIL scan_up: got %b%b want 11", up_need, down_need);
    end
    ud_mode = 2'b00; #1;
    n_checks++;
    if ({up_need, down_need} !== 2'b11) begin
      n_fail++; $display("FAIL scan_idle: got %b%b want 11", up_need, down_need);
    end
    position = 4'b0110; #1;
    n_checks++;
    if ({up_need, down_need} !== 2'b00) begin
      n_fail++; $display("FAIL bad_pos_need: got %b%b want 00", up_need, down_need);
    end
    position = 4'b1001; opendoor = 1'b1;
    step();
    opendoor = 1'b0;
    n_checks++;
    if (allReq_reg !== 4'b1001) begin
      n_fail++; $display("FAIL bad_pos_hold: got %b want 1001", allReq_reg);
    end
    position = 4'b0000; #1;
    n_checks++;
    if ({up_need, down_need} !== 2'b00) begin
      n_fail++; $display("FAIL zero_pos_need: got %b%b want 00", up_need, down_need);
    end
  endtask

  task automatic test_clear_vs_set();
    clear_all();
    position = 4'b0010; ud_mode = 2'b00;
    car_btn = 4'b0010; hall_up = 3'b010; hall_dn = 3'b001;
    step();
    car_btn = '0; hall_up = '0; hall_dn = '0;
    step();
    n_checks++;
    if (allReq_reg !== 4'b0010 || up_lamp !== 3'b010 || dn_lamp !== 3'b001) begin
      n_fail++; $display("FAIL f2_calls: got req %b up %b dn %b want 0010 010 001", allReq_reg, up_lamp, dn_lamp);
    end
    opendoor = 1'b1; hall_up = 3'b010; car_btn = 4'b1000;
    step();
    opendoor = 1'b0; hall_up = '0; car_btn = '0;
    n_checks++;
    if (allReq_reg !== 4'b1000) begin
      n_fail++; $display("FAIL clr_wins_req: got %b want 1000", allReq_reg);
    end
    n_checks++;
    if (car_lamp !== 4'b1000 || up_lamp !== 3'b000 || dn_lamp !== 3'b000) begin
      n_fail++; $display("FAIL clr_wins_lamps: got car %b up %b dn %b want 1000 000 000", car_lamp, up_lamp, dn_lamp);
    end
  endtask

  task automatic test_switch();
    clear_all();
    position = 4'b0010; ud_mode = 2'b00;
    car_btn = 4'b0101;
    step();
    car_btn = 4'b0000;
    step();
    n_checks++;
    if (allReq_reg !== 4'b0101) begin
      n_fail++; $display("FAIL sw_pre: got %b want 0101", allReq_reg);
    end
    switch = 1'b0; car_btn = 4'b0001; hall_dn = 3'b100;
    step();
    n_checks++;
    if (allReq_reg !== 4'b0000 || dn_lamp !== 3'b000) begin
      n_fail++; $display("FAIL sw_off: got req %b dn %b want 0000 000", allReq_reg, dn_lamp);
    end
    step();
    switch = 1'b1;
    step();
    n_checks++;
    if (allReq_reg !== 4'b0000) begin
      n_fail++; $display("FAIL sw_held_no_fire: got %b want 0000", allReq_reg);
    end
    car_btn = 4'b0000; hall_dn = 3'b000;
    step();
    car_btn = 4'b0001;
    step();
    car_btn = 4'b0000;
    n_checks++;
    if (allReq_reg !== 4'b0001 || {up_need, down_need} !== 2'b01) begin
      n_fail++; $display("FAIL sw_on_press: got %b need %b%b want 0001 01", allReq_reg, up_need, down_need);
    end
  endtask

  initial begin
    rst_n = 1'b0; switch = 1'b1;
    car_btn = '0; hall_up = '0; hall_dn = '0;
    position = 4'b0001; ud_mode = 2'b00; opendoor = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_set();
    test_hold_clear();
    test_scan();
    test_clear_vs_set();
    test_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
